// File: rtl/rst_seq_pkg.sv
// Purpose: shared state encoding and parameter helpers for the reset sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rst_seq_pkg;

  // Sequencer phases: wait for the synchronised release, step through the
  // outputs, idle with everything released, or hold everything for a soft reset.
  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    SW_ASSERT = 2'd3
  } rst_seq_state_e;

  // Larger of two integers, used to size the shared delay counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Purpose: reset synchroniser; asserts asynchronously, deasserts on clk.
// Latency: rst_sync rises SYNC_STAGES posedges after arst_n rises.
// Backpressure: none; free-running chain.
module rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic arst_n,
  output logic rst_sync
);

  // A chain shorter than two flops gives no metastability protection.
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("rst_sync: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] chain_q;

  // Shift a constant 1 in from the low end; async clear drops the whole chain.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Purpose: sequenced release of NUM_OUT reset domains plus handshaked soft reset.
// Latency: bit i released SYNC_STAGES+1+(i+1)*STAGE_DLY edges after arst_n rises.
// Backpressure: sw_rst_req is held pending until DONE, then acked with a 1-cycle pulse.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUT     = 3,
  parameter int STAGE_DLY   = 16,
  parameter int SW_RST_LEN  = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               rst_done
);

  // Reject parameter sets that would make the counters or sequence meaningless.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rst_seq_ctrl: SYNC_STAGES must be >= 2");
  end
  if (NUM_OUT < 1) begin : g_bad_num
    $error("rst_seq_ctrl: NUM_OUT must be >= 1");
  end
  if (STAGE_DLY < 1) begin : g_bad_dly
    $error("rst_seq_ctrl: STAGE_DLY must be >= 1");
  end
  if (SW_RST_LEN < 1) begin : g_bad_len
    $error("rst_seq_ctrl: SW_RST_LEN must be >= 1");
  end

  // One counter serves both the inter-stage gap and the soft-reset hold, so it
  // is sized for the longer of the two; idx must be able to hold NUM_OUT.
  localparam int CNT_W = $clog2(max_int(STAGE_DLY, SW_RST_LEN) + 1);
  localparam int IDX_W = $clog2(NUM_OUT + 1);

  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

  logic sync_rel;

  rst_seq_state_e     state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [NUM_OUT-1:0] rst_out_q,   rst_out_d;
  logic               done_q,      done_d;
  logic               ack_q,       ack_d;

  rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk      (clk),
    .arst_n   (arst_n),
    .rst_sync (sync_rel)
  );

  // Next-state and next-output logic; every registered output is computed here
  // so that the ports come straight from flops and cannot glitch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    done_d    = done_q;
    ack_d     = 1'b0;

    unique case (state_q)
      SYNC_WAIT: begin
        if (sync_rel) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end

      RELEASE: begin
        if (cnt_q == STG_LAST) begin
          // Release exactly the bit selected by idx; lower bits are already
          // high, higher bits stay low, so the release order is preserved.
          for (int i = 0; i < NUM_OUT; i++) begin
            if (idx_q == IDX_W'(i)) begin
              rst_out_d[i] = 1'b1;
            end
          end
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        // A request raised earlier is still high here, so it is taken now.
        if (sw_rst_req) begin
          state_d   = SW_ASSERT;
          rst_out_d = '0;
          done_d    = 1'b0;
          ack_d     = 1'b1;
          cnt_d     = '0;
        end
      end

      SW_ASSERT: begin
        if (cnt_q == SW_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = SYNC_WAIT;
      end
    endcase
  end

  // State, counters and output flops; arst_n clears them all immediately.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= SYNC_WAIT;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
    end
  end

  assign rst_out_n  = rst_out_q;
  assign rst_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Purpose: scoreboard bench for rst_seq_ctrl (default and minimal parameter sets).
// Latency: expectations are keyed on the posedge count since arst_n last rose.
// Backpressure: soft-reset requests are held until acked, or deliberately beyond.
module tb_rst_seq_ctrl;

  logic       clk;
  logic       arst_n, arst_n2;
  logic       req, req2;
  logic       ack, ack2;
  logic [2:0] rst_a;
  logic [0:0] rst_b;
  logic       done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_a  = 0;
  int edge_b  = 0;

  typedef struct {
    int         dut;
    int         edge_n;
    logic [2:0] rst;
    logic       done;
    logic       ack;
    string      name;
  } exp_t;

  exp_t sb[$];

  rst_seq_ctrl dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .sw_rst_req (req),
    .sw_rst_ack (ack),
    .rst_out_n  (rst_a),
    .rst_done   (done_a)
  );

  rst_seq_ctrl #(
    .SYNC_STAGES (2),
    .NUM_OUT     (1),
    .STAGE_DLY   (1),
    .SW_RST_LEN  (1)
  ) dut_s (
    .clk        (clk),
    .arst_n     (arst_n2),
    .sw_rst_req (req2),
    .sw_rst_ack (ack2),
    .rst_out_n  (rst_b),
    .rst_done   (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge numbering: edge 1 is the first posedge after arst_n rises.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) edge_a <= 0;
    else         edge_a <= edge_a + 1;
  end

  always @(posedge clk or negedge arst_n2) begin
    if (!arst_n2) edge_b <= 0;
    else          edge_b <= edge_b + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int d, input int e, input logic [2:0] r,
                      input logic dn, input logic ak, input string nm);
    exp_t x;
    x.dut = d; x.edge_n = e; x.rst = r; x.done = dn; x.ack = ak; x.name = nm;
    sb.push_back(x);
  endtask

  function automatic int cur_edge(input int d);
    return (d == 0) ? edge_a : edge_b;
  endfunction

  // Bounded wait until the chosen DUT's edge counter reaches target.
  task automatic wait_to(input int d, input int target);
    int guard = 0;
    while (cur_edge(d) < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cur_edge(d) < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_to dut%0d: got edge %0d expected %0d", d, cur_edge(d), target);
    end
  endtask

  // Monitor: compares scoreboard entries due at this edge, plus the ordering
  // and rst_done invariants on every cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      int         ce;
      logic       live;
      logic [2:0] r;
      logic       dn, ak;
      ce   = cur_edge(sb[i].dut);
      live = (sb[i].dut == 0) ? arst_n : arst_n2;
      r    = (sb[i].dut == 0) ? rst_a  : {2'b00, rst_b};
      dn   = (sb[i].dut == 0) ? done_a : done_b;
      ak   = (sb[i].dut == 0) ? ack    : ack2;
      if (live && ce == sb[i].edge_n) begin
        chk({sb[i].name, "_rst"},  int'(r),  int'(sb[i].rst));
        chk({sb[i].name, "_done"}, int'(dn), int'(sb[i].done));
        chk({sb[i].name, "_ack"},  int'(ak), int'(sb[i].ack));
        sb.delete(i);
      end else if (live && ce > sb[i].edge_n) begin
        chk({sb[i].name, "_missed"}, ce, sb[i].edge_n);
        sb.delete(i);
      end
    end
    chk("inv_done_a",  int'(done_a), int'(&rst_a));
    chk("inv_order_a", int'((rst_a & (rst_a + 3'd1)) == 3'd0), 1);
    chk("inv_done_b",  int'(done_b), int'(&rst_b));
  end

  initial begin
    arst_n = 1'b0; arst_n2 = 1'b0; req = 1'b0; req2 = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rst",  int'(rst_a), 0);
    chk("reset_done", int'(done_a), 0);
    chk("reset_ack",  int'(ack), 0);
    chk("reset_rst_s", int'(rst_b), 0);

    // Power-up: RELEASE entered at edge 3, releases 19/35/51.
    arst_n = 1'b1;
    push(0,  2, 3'b000, 1'b0, 1'b0, "pu_e2");
    push(0, 18, 3'b000, 1'b0, 1'b0, "pu_e18");
    push(0, 19, 3'b001, 1'b0, 1'b0, "pu_e19");
    push(0, 34, 3'b001, 1'b0, 1'b0, "pu_e34");
    push(0, 35, 3'b011, 1'b0, 1'b0, "pu_e35");
    push(0, 50, 3'b011, 1'b0, 1'b0, "pu_e50");
    push(0, 51, 3'b111, 1'b1, 1'b0, "pu_e51");
    wait_to(0, 52);

    // Soft reset accepted at D=53, held for exactly one edge.
    req = 1'b1;
    push(0, 53, 3'b000, 1'b0, 1'b1, "sw_ack");
    push(0, 54, 3'b000, 1'b0, 1'b0, "sw_ack_drop");
    push(0, 76, 3'b000, 1'b0, 1'b0, "sw_d23");
    push(0, 77, 3'b001, 1'b0, 1'b0, "sw_d24");
    push(0, 92, 3'b001, 1'b0, 1'b0, "sw_d39");
    push(0, 93, 3'b011, 1'b0, 1'b0, "sw_d40");
    push(0, 108, 3'b011, 1'b0, 1'b0, "sw_d55");
    push(0, 109, 3'b111, 1'b1, 1'b0, "sw_d56");
    wait_to(0, 53);
    req = 1'b0;
    wait_to(0, 110);

    // Held request: D2=111, second acceptance on first DONE edge 168.
    req = 1'b1;
    push(0, 111, 3'b000, 1'b0, 1'b1, "held_ack1");
    push(0, 112, 3'b000, 1'b0, 1'b0, "held_ack1_drop");
    push(0, 135, 3'b001, 1'b0, 1'b0, "held_r0");
    push(0, 167, 3'b111, 1'b1, 1'b0, "held_done");
    push(0, 168, 3'b000, 1'b0, 1'b1, "held_ack2");
    push(0, 169, 3'b000, 1'b0, 1'b0, "held_ack2_drop");
    push(0, 192, 3'b001, 1'b0, 1'b0, "held2_r0");
    push(0, 224, 3'b111, 1'b1, 1'b0, "held2_done");
    wait_to(0, 168);
    req = 1'b0;
    wait_to(0, 225);

    // Async assert from DONE.
    arst_n = 1'b0;
    #1;
    chk("async_done_rst",  int'(rst_a), 0);
    chk("async_done_done", int'(done_a), 0);
    repeat (3) @(negedge clk);

    // Async assert between edges 40 and 41.
    arst_n = 1'b1;
    push(0, 19, 3'b001, 1'b0, 1'b0, "a40_e19");
    push(0, 35, 3'b011, 1'b0, 1'b0, "a40_e35");
    push(0, 39, 3'b011, 1'b0, 1'b0, "a40_e39");
    wait_to(0, 40);
    arst_n = 1'b0;
    #1;
    chk("async40_rst",  int'(rst_a), 0);
    chk("async40_done", int'(done_a), 0);
    repeat (3) @(negedge clk);

    // Async assert over edge 25.
    arst_n = 1'b1;
    push(0, 18, 3'b000, 1'b0, 1'b0, "a25_e18");
    push(0, 19, 3'b001, 1'b0, 1'b0, "a25_e19");
    wait_to(0, 24);
    arst_n = 1'b0;
    #1;
    chk("async25_rst", int'(rst_a), 0);
    repeat (3) @(negedge clk);

    // Fresh sequence with an early request from edge 10; DONE is entered at
    // edge 51, so the first edge spent in DONE (acceptance) is edge 52.
    arst_n = 1'b1;
    push(0,   2, 3'b000, 1'b0, 1'b0, "re_e2");
    push(0,  19, 3'b001, 1'b0, 1'b0, "re_e19");
    push(0,  35, 3'b011, 1'b0, 1'b0, "re_e35");
    push(0,  51, 3'b111, 1'b1, 1'b0, "early_e51");
    push(0,  52, 3'b000, 1'b0, 1'b1, "early_ack");
    push(0,  53, 3'b000, 1'b0, 1'b0, "early_ack_drop");
    push(0,  75, 3'b000, 1'b0, 1'b0, "early_d23");
    push(0,  76, 3'b001, 1'b0, 1'b0, "early_d24");
    push(0,  92, 3'b011, 1'b0, 1'b0, "early_d40");
    push(0, 108, 3'b111, 1'b1, 1'b0, "early_d56");
    wait_to(0, 9);
    req = 1'b1;
    wait_to(0, 52);
    req = 1'b0;
    wait_to(0, 109);

    // Minimal parameter sweep: release at edge 4, soft at D=6 releases at 8.
    arst_n2 = 1'b1;
    push(1, 3, 3'b000, 1'b0, 1'b0, "sweep_e3");
    push(1, 4, 3'b001, 1'b1, 1'b0, "sweep_e4");
    wait_to(1, 5);
    req2 = 1'b1;
    push(1, 6, 3'b000, 1'b0, 1'b1, "sweep_ack");
    push(1, 7, 3'b000, 1'b0, 1'b0, "sweep_d1");
    push(1, 8, 3'b001, 1'b1, 1'b0, "sweep_d2");
    wait_to(1, 6);
    req2 = 1'b0;
    wait_to(1, 9);

    // Anything still queued was never observed.
    while (sb.size() != 0) begin
      chk({sb[0].name, "_unseen"}, 1, 0);
      sb.delete(0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
